// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampled UART receiver with configurable framing
// and a valid/ready output register that flags dropped frames.
module uart_rx_cfg #(
  parameter int DBIT      = 8,
  parameter int OS        = 16,
  parameter bit PAR_EN    = 1'b0,
  parameter bit PAR_ODD   = 1'b0,
  parameter int STOP_BITS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Data_in,
  input  logic            tick,
  output logic [DBIT-1:0] dout,
  output logic            valid,
  input  logic            ready,
  output logic            frame_err,
  output logic            parity_err,
  output logic            overrun,
  output logic            busy
);
  localparam int TW = $clog2(OS);
  localparam int BW = $clog2(DBIT + 1);
  localparam logic [TW-1:0] T_HALF = TW'(OS / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OS - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DBIT - 1);
  localparam logic [BW-1:0] S_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [DBIT-1:0]   sreg_q, sreg_d;
  logic              ferr_q, ferr_d;
  logic              perr_q, perr_d;
  logic [1:0]        sync_q;
  logic              rx_s;
  logic              mid;
  logic              done;
  logic              hshk;

  assign rx_s = sync_q[1];
  assign mid  = (tcnt_q == T_LAST);
  assign busy = (state_q != IDLE);
  assign hshk = valid & ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      sreg_q  <= '0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], Data_in};
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      sreg_q  <= sreg_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    sreg_d  = sreg_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    done    = 1'b0;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            tcnt_d  = '0;
          end
        end
        START: begin
          if (tcnt_q == T_HALF) begin
            tcnt_d  = '0;
            bcnt_d  = '0;
            ferr_d  = 1'b0;
            perr_d  = 1'b0;
            state_d = rx_s ? IDLE : DATA;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        DATA: begin
          if (mid) begin
            tcnt_d = '0;
            sreg_d = {rx_s, sreg_q[DBIT-1:1]};
            if (bcnt_q == B_LAST) begin
              bcnt_d  = '0;
              state_d = PAR_EN ? PARITY : STOP;
            end else begin
              bcnt_d = bcnt_q + BW'(1);
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        PARITY: begin
          if (mid) begin
            tcnt_d  = '0;
            perr_d  = ((^sreg_q) ^ rx_s) != PAR_ODD;
            state_d = STOP;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        STOP: begin
          if (mid) begin
            tcnt_d = '0;
            ferr_d = ferr_q | ~rx_s;
            if (bcnt_q == S_LAST) begin
              bcnt_d  = '0;
              done    = 1'b1;
              state_d = IDLE;
            end else begin
              bcnt_d = bcnt_q + BW'(1);
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A finished frame is only dropped when the previous one is still unread.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout       <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (hshk) overrun <= 1'b0;
      if (done) begin
        if (!valid || ready) begin
          dout       <= sreg_q;
          frame_err  <= ferr_d;
          parity_err <= perr_d & PAR_EN;
          valid      <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (hshk) begin
        valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed frames into four receiver configurations,
// checked against hand-computed data and status flags.
module tb_uart_rx_cfg;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b0;
  logic ready = 1'b1;
  logic line = 1'b1;
  int   sel = 0;
  int   total = 0;
  int   bad = 0;

  logic din0, din1, din2, din3;
  logic [7:0] dout0, dout1, dout2;
  logic [6:0] dout3;
  logic v0, v1, v2, v3;
  logic fe0, fe1, fe2, fe3;
  logic pe0, pe1, pe2, pe3;
  logic ov0, ov1, ov2, ov3;
  logic b0, b1, b2, b3;

  int         nv [4];
  logic [8:0] cd [4];
  logic       cf [4];
  logic       cp [4];
  logic       co [4];

  assign din0 = (sel == 0) ? line : 1'b1;
  assign din1 = (sel == 1) ? line : 1'b1;
  assign din2 = (sel == 2) ? line : 1'b1;
  assign din3 = (sel == 3) ? line : 1'b1;

  always #5 clk = ~clk;
  always @(negedge clk) tick <= ~tick;

  uart_rx_cfg u0 (
    .clk(clk), .reset(reset), .Data_in(din0), .tick(tick),
    .dout(dout0), .valid(v0), .ready(ready), .frame_err(fe0),
    .parity_err(pe0), .overrun(ov0), .busy(b0));

  uart_rx_cfg #(.PAR_EN(1'b1), .PAR_ODD(1'b0)) u1 (
    .clk(clk), .reset(reset), .Data_in(din1), .tick(tick),
    .dout(dout1), .valid(v1), .ready(ready), .frame_err(fe1),
    .parity_err(pe1), .overrun(ov1), .busy(b1));

  uart_rx_cfg #(.STOP_BITS(2)) u2 (
    .clk(clk), .reset(reset), .Data_in(din2), .tick(tick),
    .dout(dout2), .valid(v2), .ready(ready), .frame_err(fe2),
    .parity_err(pe2), .overrun(ov2), .busy(b2));

  uart_rx_cfg #(.DBIT(7), .OS(8)) u3 (
    .clk(clk), .reset(reset), .Data_in(din3), .tick(tick),
    .dout(dout3), .valid(v3), .ready(ready), .frame_err(fe3),
    .parity_err(pe3), .overrun(ov3), .busy(b3));

  initial foreach (nv[i]) nv[i] = 0;

  always @(negedge clk) begin
    if (v0 && ready) begin
      nv[0] <= nv[0] + 1; cd[0] <= {1'b0, dout0};
      cf[0] <= fe0; cp[0] <= pe0; co[0] <= ov0;
    end
    if (v1 && ready) begin
      nv[1] <= nv[1] + 1; cd[1] <= {1'b0, dout1};
      cf[1] <= fe1; cp[1] <= pe1; co[1] <= ov1;
    end
    if (v2 && ready) begin
      nv[2] <= nv[2] + 1; cd[2] <= {1'b0, dout2};
      cf[2] <= fe2; cp[2] <= pe2; co[2] <= ov2;
    end
    if (v3 && ready) begin
      nv[3] <= nv[3] + 1; cd[3] <= {2'b0, dout3};
      cf[3] <= fe3; cp[3] <= pe3; co[3] <= ov3;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!tick) @(posedge clk);
    end
    #1;
  endtask

  task automatic send(input int k, input logic [8:0] data, input int nb,
                      input int os, input bit par, input logic pbit,
                      input logic [1:0] stops, input int nstop);
    sel  = k;
    line = 1'b0;
    wait_ticks(os);
    for (int i = 0; i < nb; i++) begin
      line = data[i];
      wait_ticks(os);
    end
    if (par) begin
      line = pbit;
      wait_ticks(os);
    end
    for (int i = 0; i < nstop; i++) begin
      line = stops[i];
      wait_ticks(os);
    end
    line = 1'b1;
    wait_ticks(os);
  endtask

  int n;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(b0), 0);
    check("rst_valid", 32'(v0), 0);
    check("rst_dout", 32'(dout0), 0);
    check("rst_flags", 32'({fe0, pe0, ov0}), 0);
    reset = 1'b0;
    wait_ticks(4);

    n = nv[0];
    send(0, 9'h05A, 8, 16, 1'b0, 1'b0, 2'b01, 1);
    check("f5a_cnt", 32'(nv[0] - n), 1);
    check("f5a_dout", 32'(cd[0]), 32'h5A);
    check("f5a_fe", 32'(cf[0]), 0);
    check("f5a_pe", 32'(cp[0]), 0);
    check("f5a_ov", 32'(co[0]), 0);

    send(0, 9'h0A5, 8, 16, 1'b0, 1'b0, 2'b00, 1);
    check("stop0_dout", 32'(cd[0]), 32'hA5);
    check("stop0_fe", 32'(cf[0]), 1);
    wait_ticks(16);

    n = nv[0];
    sel = 0;
    line = 1'b0;
    wait_ticks(4);
    @(negedge clk);
    check("glitch_busy", 32'(b0), 1);
    #1 line = 1'b1;
    wait_ticks(16);
    @(negedge clk);
    check("glitch_idle", 32'(b0), 0);
    check("glitch_cnt", 32'(nv[0] - n), 0);

    n = nv[1];
    send(1, 9'h003, 8, 16, 1'b1, 1'b1, 2'b01, 1);
    check("par1_cnt", 32'(nv[1] - n), 1);
    check("par1_dout", 32'(cd[1]), 32'h03);
    check("par1_pe", 32'(cp[1]), 1);
    send(1, 9'h003, 8, 16, 1'b1, 1'b0, 2'b01, 1);
    check("par0_pe", 32'(cp[1]), 0);
    check("par0_fe", 32'(cf[1]), 0);

    send(2, 9'h0FF, 8, 16, 1'b0, 1'b0, 2'b01, 2);
    check("stop2_dout", 32'(cd[2]), 32'hFF);
    check("stop2_fe", 32'(cf[2]), 1);
    wait_ticks(16);
    send(2, 9'h0C6, 8, 16, 1'b0, 1'b0, 2'b11, 2);
    check("stop2ok_dout", 32'(cd[2]), 32'hC6);
    check("stop2ok_fe", 32'(cf[2]), 0);

    ready = 1'b0;
    send(0, 9'h011, 8, 16, 1'b0, 1'b0, 2'b01, 1);
    send(0, 9'h022, 8, 16, 1'b0, 1'b0, 2'b01, 1);
    @(negedge clk);
    check("ovr_valid", 32'(v0), 1);
    check("ovr_dout", 32'(dout0), 32'h11);
    check("ovr_flag", 32'(ov0), 1);
    #1 ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
    @(negedge clk);
    check("ack_valid", 32'(v0), 0);
    check("ack_ovr", 32'(ov0), 0);
    ready = 1'b1;

    n = nv[0];
    sel = 0;
    line = 1'b0;
    wait_ticks(16);
    line = 1'b1;
    wait_ticks(16);
    line = 1'b1;
    wait_ticks(16);
    line = 1'b0;
    wait_ticks(16);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rstmid_busy", 32'(b0), 0);
    check("rstmid_valid", 32'(v0), 0);
    @(negedge clk);
    reset = 1'b0;
    line = 1'b1;
    wait_ticks(32);
    send(0, 9'h03C, 8, 16, 1'b0, 1'b0, 2'b01, 1);
    check("rstmid_cnt", 32'(nv[0] - n), 1);
    check("rstmid_dout", 32'(cd[0]), 32'h3C);

    n = nv[3];
    send(3, 9'h05A, 7, 8, 1'b0, 1'b0, 2'b01, 1);
    check("d7_cnt", 32'(nv[3] - n), 1);
    check("d7_dout", 32'(cd[3]), 32'h5A);
    check("d7_fe", 32'(cf[3]), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter DBIT, default 8, meaning data bits per frame, legal 5..9.
REQ-002 SHALL have parameter OS, default 16, meaning ticks per bit period, even, legal 8..32.
REQ-003 SHALL have parameter PAR_EN, default 0, meaning parity bit present when 1.
REQ-004 SHALL have parameter PAR_ODD, default 0, meaning odd parity when 1 and even parity when 0; ignored when PAR_EN=0.
REQ-005 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked, legal 1 or 2.
REQ-006 SHALL have port clk, input, 1, the single system clock; all logic on rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port Data_in, input, 1, asynchronous serial line, idle high.
REQ-009 SHALL have port tick, input, 1, one-clk oversample enable at OS x baud.
REQ-010 SHALL have port dout, output, DBIT, received data word, LSB first on line.
REQ-011 SHALL have port valid, output, 1, dout and status flags hold an unread frame.
REQ-012 SHALL have port ready, input, 1, consumer accepts the frame when valid and ready are both high.
REQ-013 SHALL have port frame_err, output, 1, any checked stop bit sampled 0; qualified by valid.
REQ-014 SHALL have port parity_err, output, 1, parity mismatch; qualified by valid; constant 0 when PAR_EN=0.
REQ-015 SHALL have port overrun, output, 1, at least one frame was dropped while valid was high.
REQ-016 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-017 SHALL pass Data_in through a 2-flop synchronizer; all sampling uses the synchronized value rx_s.
REQ-018 SHALL implement states IDLE, START, DATA, PARITY, STOP, using a tick counter of ceil(log2(OS)) bits and a bit counter.
REQ-019 SHALL, in IDLE, move to START with the tick counter cleared on a tick when rx_s=0.
REQ-020 SHALL, in START, increment the tick counter per tick; at count OS/2-1 it goes to DATA with counter cleared if rx_s=0, else back to IDLE (glitch reject, no output).
REQ-021 SHALL, in DATA, PARITY and STOP, sample rx_s on the tick at which the tick counter equals OS-1, then clear the counter (mid-bit sampling).
REQ-022 SHALL shift DATA samples in LSB first and move on after exactly DBIT samples: to PARITY if PAR_EN=1, else to STOP.
REQ-023 SHALL, in PARITY, set the parity error when the XOR of the data bits and the parity sample does not equal PAR_ODD.
REQ-024 SHALL, in STOP, take STOP_BITS samples, set the frame error if any sample is 0, then return to IDLE.
REQ-025 SHALL complete the frame on the clk edge of the last stop sample, going to IDLE and updating the output register on that same edge.
REQ-026 SHALL, on completion when valid=0, or valid=1 with ready=1 in the same cycle, load dout, frame_err and parity_err and set valid=1.
REQ-027 SHALL, on completion when valid=1 and ready=0, keep the old dout and flags, discard the new frame and set overrun.
REQ-028 SHALL, on a handshake (valid and ready) with no simultaneous completion, clear valid on the next edge; overrun clears on any handshake.
REQ-029 SHALL hold dout and all flags stable while valid=1 and ready=0.
REQ-030 SHALL ignore all clocks without tick for state advance; ready and the handshake are evaluated every clk.
REQ-031 SHALL allow back-to-back frames: a start bit immediately following the last stop sample is detected on the next tick.

Reset
REQ-032 SHALL, on reset assertion, immediately force: state IDLE, counters 0, shift register 0, synchronizer flops 1, dout 0, valid 0, frame_err 0, parity_err 0, overrun 0, busy 0.
REQ-033 SHALL discard a partially received frame on reset mid-frame, with no valid pulse after release.
REQ-034 SHALL leave the synchronizer high on reset release, so a line held low produces no start detection until a 1 to 0 transition has propagated.

Verification
REQ-035 Default parameters, frame 0x5A 8N1, ready=1 -> one valid, dout=0x5A, frame_err=0, parity_err=0, overrun=0.
REQ-036 Data_in low for 4 ticks then high -> state returns to IDLE, busy falls, valid stays 0.
REQ-037 PAR_EN=1, PAR_ODD=0, frame 0x03 with parity bit 1 -> valid, dout=0x03, parity_err=1; with parity bit 0 -> parity_err=0.
REQ-038 STOP_BITS=2, second stop bit driven 0, frame 0xFF -> valid, dout=0xFF, frame_err=1.
REQ-039 ready=0, frames 0x11 then 0x22 -> dout=0x11, overrun=1; one ready cycle -> valid=0, overrun=0.
REQ-040 Reset pulsed after 3 data bits of 0xC3, then a full 0x3C frame -> only one valid, dout=0x3C; DBIT=7 with OS=8 repeats REQ-035 with 0x5A.
